// File: rtl/moore_1101_detector.sv
// Moore FSM detecting the serial pattern 1101 with overlap; y flags the match state.
// Current and next state are exposed for debug.
module moore_1101_detector (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  output logic       y,
  output logic [2:0] cs,
  output logic [2:0] ns
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_e;

  always_comb begin
    ns = S0;
    case (cs)
      S0:      ns = x ? S1 : S0;
      S1:      ns = x ? S2 : S0;
      S2:      ns = x ? S2 : S3;
      S3:      ns = x ? S4 : S0;
      // Trailing 1 of a match doubles as the "11" prefix of the next one.
      S4:      ns = x ? S2 : S0;
      default: ns = S0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs <= S0;
    end else begin
      cs <= ns;
    end
  end

  assign y = (cs == S4);

endmodule

// File: tb/tb_moore_1101_detector.sv
// Directed bench for moore_1101_detector: expected {cs,y} queued at drive time,
// popped and checked one step after the sampling edge.
module tb_moore_1101_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       x;
  logic       y;
  logic [2:0] cs;
  logic [2:0] ns;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];

  moore_1101_detector dut (
    .clk(clk),
    .rst(rst),
    .x  (x),
    .y  (y),
    .cs (cs),
    .ns (ns)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive x away from the edge, queue expected {cs,y}, compare after the edge.
  task automatic step(input string tag, input logic xv, input logic [2:0] exp_cs);
    logic [3:0] e;
    @(negedge clk);
    x = xv;
    exp_q.push_back({exp_cs, exp_cs == 3'b100});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {cs, y}, e);
    end
  endtask

  initial begin
    rst = 1'b0;
    x   = 1'b0;

    // Reset held: clocks and x activity must not move the state.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x = i[0];
      @(posedge clk);
      #1;
      chk("reset_hold", {cs, y}, 4'b0000);
    end
    @(negedge clk);
    x = 1'b1;
    #1;
    chk("reset_ns_x1", {1'b0, ns}, 4'b0001);
    x = 1'b0;
    #1;
    chk("reset_ns_x0", {1'b0, ns}, 4'b0000);
    rst = 1'b1;

    // Basic match.
    step("basic_e1", 1'b1, 3'b001);
    step("basic_e2", 1'b1, 3'b010);
    step("basic_e3", 1'b0, 3'b011);
    step("basic_e4", 1'b1, 3'b100);
    step("basic_e5", 1'b0, 3'b000);

    // Overlapping matches.
    step("ovl_e1", 1'b1, 3'b001);
    step("ovl_e2", 1'b1, 3'b010);
    step("ovl_e3", 1'b0, 3'b011);
    step("ovl_e4", 1'b1, 3'b100);
    step("ovl_e5", 1'b1, 3'b010);
    step("ovl_e6", 1'b0, 3'b011);
    step("ovl_e7", 1'b1, 3'b100);
    step("ovl_e8", 1'b0, 3'b000);

    // Long run of ones.
    step("ones_e1", 1'b1, 3'b001);
    step("ones_e2", 1'b1, 3'b010);
    step("ones_e3", 1'b1, 3'b010);
    step("ones_e4", 1'b1, 3'b010);
    step("ones_e5", 1'b0, 3'b011);
    step("ones_e6", 1'b1, 3'b100);
    step("ones_e7", 1'b0, 3'b000);

    // Near-misses never reach the match state.
    step("miss_e1", 1'b1, 3'b001);
    step("miss_e2", 1'b0, 3'b000);
    step("miss_e3", 1'b1, 3'b001);
    step("miss_e4", 1'b1, 3'b010);
    step("miss_e5", 1'b0, 3'b011);
    step("miss_e6", 1'b0, 3'b000);
    step("miss_e7", 1'b1, 3'b001);
    step("miss_e8", 1'b0, 3'b000);
    step("miss_e9", 1'b1, 3'b001);
    step("miss_e10", 1'b0, 3'b000);

    // Asynchronous reset between edges discards the 110 prefix.
    step("arst_e1", 1'b1, 3'b001);
    step("arst_e2", 1'b1, 3'b010);
    step("arst_e3", 1'b0, 3'b011);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_immediate", {cs, y}, 4'b0000);
    rst = 1'b1;
    step("arst_after", 1'b1, 3'b001);
    step("arst_idle", 1'b0, 3'b000);

    // Illegal state self-recovers.
    @(negedge clk);
    force dut.cs = 3'b110;
    x = 1'b0;
    #1;
    chk("illegal_x0", {ns, y}, 4'b0000);
    x = 1'b1;
    #1;
    chk("illegal_x1", {ns, y}, 4'b0000);
    release dut.cs;
    #1;
    chk("illegal_held", {cs, y}, 4'b1100);
    @(posedge clk);
    #1;
    chk("illegal_recover", {cs, y}, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
